// File: rtl/health_pkg.sv
// Shared definitions for the nervous alarm path: detector code values,
// the alarm manager state encoding and the width of the run counters.
package health_pkg;

    localparam logic [1:0] NERV_NORMAL   = 2'b00;
    localparam logic [1:0] NERV_MILD     = 2'b01;
    localparam logic [1:0] NERV_MODERATE = 2'b10;
    localparam logic [1:0] NERV_SEVERE   = 2'b11;

    // Run counters only ever need to reach 15 (largest legal threshold).
    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIRM  = 2'd1,
        ALARM    = 2'd2,
        CLEARING = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/nervous_alarm_manager_if.sv
// Bundle between the nervous shock detector side and the alarm manager.
// The master drives the detector code and operator ack; the slave (the
// alarm manager) returns the latched alarm status.
interface nervous_alarm_manager_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       nervousAbnormality;
    logic             ack;
    logic [1:0]       alarm_level;
    logic             alarm_active;
    logic             alarm_new;
    logic [CNT_W-1:0] event_count;

    modport master (
        output nervousAbnormality,
        output ack,
        input  alarm_level,
        input  alarm_active,
        input  alarm_new,
        input  event_count
    );

    modport slave (
        input  nervousAbnormality,
        input  ack,
        output alarm_level,
        output alarm_active,
        output alarm_new,
        output event_count
    );
endinterface

// File: rtl/run_length_counter.sv
// Counts consecutive enabled samples equal to the value that started the
// run. A different sample restarts the run at 1; a dropped enable empties
// it. The hit flag is combinational and fires on the sample that brings
// the run to THRESH, after which the run starts over.
module run_length_counter
    import health_pkg::*;
#(
    parameter int VAL_W  = 2,
    parameter int THRESH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [VAL_W-1:0] sample,
    output logic             hit
);

    logic [VAL_W-1:0] held;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;

    // Length the run would have after this sample and whether it qualifies.
    always_comb begin
        run_next = RUN_W'(1);
        if (run != '0 && sample == held) begin
            run_next = run + RUN_W'(1);
        end
        hit = en && (run_next == RUN_W'(THRESH));
    end

    // Hold the run value and length; empty on idle or once the run is consumed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run  <= '0;
            held <= '0;
        end else if (!en || hit) begin
            run  <= '0;
        end else begin
            run  <= run_next;
            held <= sample;
        end
    end

endmodule

// File: rtl/nervous_alarm_manager.sv
// Nervous alarm manager: debounces the detector code, latches and escalates
// the alarm level, clears it after operator ack plus a quiet period, and
// counts confirmed events (saturating).
// Build option: define NERVOUS_AUTO_CLEAR_EN to start clearing on a normal
// code without waiting for ack (the ack port is then ignored).
module nervous_alarm_manager
    import health_pkg::*;
#(
    parameter int CONFIRM_CYCLES = 3,
    parameter int CLEAR_CYCLES   = 4,
    parameter int CNT_W          = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    nervous_alarm_manager_if.slave  bus
);

    alarm_state_t     state;
    logic [1:0]       code;
    logic [1:0]       level;
    logic             active;
    logic             new_pulse;
    logic [CNT_W-1:0] count;

    logic             esc_en;
    logic             clr_en;
    logic             clr_start;
    logic             conf_hit;
    logic             clr_hit;

    assign code = bus.nervousAbnormality;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Decide which run counter is live this cycle for the current state.
    always_comb begin
        esc_en = 1'b0;
        clr_en = 1'b0;
`ifdef NERVOUS_AUTO_CLEAR_EN
        clr_start = (code == NERV_NORMAL);
`else
        clr_start = (code == NERV_NORMAL) && bus.ack;
`endif
        case (state)
            IDLE, CONFIRM: esc_en = (code != NERV_NORMAL);
            ALARM: begin
                esc_en = (code > level);
                clr_en = clr_start;
            end
            CLEARING: begin
                esc_en = (code > level);
                clr_en = (code == NERV_NORMAL);
            end
            default: ;
        endcase
    end

    run_length_counter #(
        .VAL_W  (2),
        .THRESH (CONFIRM_CYCLES)
    ) u_confirm_run (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (esc_en),
        .sample  (code),
        .hit     (conf_hit)
    );

    run_length_counter #(
        .VAL_W  (2),
        .THRESH (CLEAR_CYCLES)
    ) u_clear_run (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (clr_en),
        .sample  (code),
        .hit     (clr_hit)
    );

    // Alarm state machine with registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            level     <= NERV_NORMAL;
            active    <= 1'b0;
            new_pulse <= 1'b0;
            count     <= '0;
        end else begin
            new_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (code != NERV_NORMAL) begin
                        if (conf_hit) begin
                            state     <= ALARM;
                            active    <= 1'b1;
                            level     <= code;
                            new_pulse <= 1'b1;
                            count     <= sat_inc(count);
                        end else begin
                            state <= CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (code == NERV_NORMAL) begin
                        state <= IDLE;
                    end else if (conf_hit) begin
                        state     <= ALARM;
                        active    <= 1'b1;
                        level     <= code;
                        new_pulse <= 1'b1;
                        count     <= sat_inc(count);
                    end
                end
                ALARM: begin
                    if (clr_start) begin
                        if (clr_hit) begin
                            state  <= IDLE;
                            active <= 1'b0;
                            level  <= NERV_NORMAL;
                        end else begin
                            state <= CLEARING;
                        end
                    end else if (conf_hit) begin
                        level     <= code;
                        new_pulse <= 1'b1;
                        count     <= sat_inc(count);
                    end
                end
                CLEARING: begin
                    if (code == NERV_NORMAL) begin
                        if (clr_hit) begin
                            state  <= IDLE;
                            active <= 1'b0;
                            level  <= NERV_NORMAL;
                        end
                    end else begin
                        state <= ALARM;
                        if (conf_hit) begin
                            level     <= code;
                            new_pulse <= 1'b1;
                            count     <= sat_inc(count);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alarm_level  = level;
    assign bus.alarm_active = active;
    assign bus.alarm_new    = new_pulse;
    assign bus.event_count  = count;

endmodule

// File: tb/tb_nervous_alarm_manager.sv
// Bench for nervous_alarm_manager: three instances (default, 2-bit counter,
// and single-cycle confirm/clear) driven with the same code/ack stream.
module tb_nervous_alarm_manager;

    localparam int NI = 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] code_d;
    logic       ack_d;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clock = ~clock;

    nervous_alarm_manager_if #(.CNT_W(8)) if0 ();
    nervous_alarm_manager_if #(.CNT_W(2)) if1 ();
    nervous_alarm_manager_if #(.CNT_W(8)) if2 ();

    assign if0.nervousAbnormality = code_d;
    assign if1.nervousAbnormality = code_d;
    assign if2.nervousAbnormality = code_d;
    assign if0.ack = ack_d;
    assign if1.ack = ack_d;
    assign if2.ack = ack_d;

    nervous_alarm_manager #(.CONFIRM_CYCLES(3), .CLEAR_CYCLES(4), .CNT_W(8)) u0 (
        .clock(clock), .reset_n(reset_n), .bus(if0));
    nervous_alarm_manager #(.CONFIRM_CYCLES(3), .CLEAR_CYCLES(4), .CNT_W(2)) u1 (
        .clock(clock), .reset_n(reset_n), .bus(if1));
    nervous_alarm_manager #(.CONFIRM_CYCLES(1), .CLEAR_CYCLES(1), .CNT_W(8)) u2 (
        .clock(clock), .reset_n(reset_n), .bus(if2));

    // Reference model: phase 0 idle, 1 confirming, 2 alarm, 3 clearing.
    int cc_p [NI] = '{3, 3, 1};
    int cl_p [NI] = '{4, 4, 1};
    int cmax [NI] = '{255, 3, 255};
    int m_ph [NI];
    int m_cand [NI];
    int m_run [NI];
    int m_clr [NI];
    int m_lvl [NI];
    int m_new [NI];
    int m_cnt [NI];

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_ph[k] = 0; m_cand[k] = 0; m_run[k] = 0; m_clr[k] = 0;
            m_lvl[k] = 0; m_new[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_confirm(input int k);
        m_lvl[k] = m_cand[k];
        m_new[k] = 1;
        if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        m_ph[k]  = 2;
        m_run[k] = 0;
    endtask

    task automatic model_step(input int c, input int a);
        int auto_clr;
`ifdef NERVOUS_AUTO_CLEAR_EN
        auto_clr = 1;
`else
        auto_clr = 0;
`endif
        for (int k = 0; k < NI; k++) begin
            m_new[k] = 0;
            case (m_ph[k])
                0: if (c != 0) begin
                    m_cand[k] = c; m_run[k] = 1;
                    if (m_run[k] >= cc_p[k]) model_confirm(k);
                    else m_ph[k] = 1;
                end
                1: if (c == 0) begin
                    m_ph[k] = 0; m_run[k] = 0;
                end else if (c == m_cand[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == cc_p[k]) model_confirm(k);
                end else begin
                    m_cand[k] = c; m_run[k] = 1;
                end
                2: if (c > m_lvl[k]) begin
                    if (m_run[k] > 0 && c == m_cand[k]) m_run[k] = m_run[k] + 1;
                    else begin m_cand[k] = c; m_run[k] = 1; end
                    if (m_run[k] == cc_p[k]) model_confirm(k);
                end else begin
                    m_run[k] = 0;
                    if (c == 0 && (a != 0 || auto_clr != 0)) begin
                        m_clr[k] = 1;
                        if (m_clr[k] >= cl_p[k]) begin
                            m_ph[k] = 0; m_lvl[k] = 0; m_clr[k] = 0;
                        end else m_ph[k] = 3;
                    end
                end
                default: if (c == 0) begin
                    m_clr[k] = m_clr[k] + 1;
                    if (m_clr[k] == cl_p[k]) begin
                        m_ph[k] = 0; m_lvl[k] = 0; m_clr[k] = 0;
                    end
                end else begin
                    m_ph[k] = 2; m_clr[k] = 0; m_run[k] = 0;
                    if (c > m_lvl[k]) begin
                        m_cand[k] = c; m_run[k] = 1;
                        if (m_run[k] == cc_p[k]) model_confirm(k);
                    end
                end
            endcase
        end
    endtask

    task automatic step(input logic [1:0] c, input logic a);
        @(negedge clock);
        code_d = c;
        ack_d  = a;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        code_d  = 2'b00;
        ack_d   = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] g0;
        logic [5:0]  g1;
        logic [11:0] g2;
        reset_n = 1'b0;
        code_d  = 2'b11;
        ack_d   = 1'b1;
        #12;
        g0 = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
        g1 = {if1.alarm_level, if1.alarm_active, if1.alarm_new, if1.event_count};
        g2 = {if2.alarm_level, if2.alarm_active, if2.alarm_new, if2.event_count};
        vec_cnt++; if (g0 !== 12'h000) begin err_cnt++; $display("FAIL reset_u0: got %h want 000", g0); end
        vec_cnt++; if (g1 !== 6'h00)   begin err_cnt++; $display("FAIL reset_u1: got %h want 00", g1); end
        vec_cnt++; if (g2 !== 12'h000) begin err_cnt++; $display("FAIL reset_u2: got %h want 000", g2); end
        do_reset();
        step(2'b00, 1'b0);
        g0 = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
        vec_cnt++; if (g0 !== 12'h000) begin err_cnt++; $display("FAIL reset_idle_u0: got %h want 000", g0); end
    endtask

    task automatic test_confirm();
        logic [11:0] g;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(2'b01, 1'b0);
            g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
            vec_cnt++; if (g !== {2'd0, 1'b0, 1'b0, 8'd0}) begin err_cnt++; $display("FAIL confirm_wait%0d: got %h want 000", i, g); end
        end
        step(2'b01, 1'b0);
        g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
        vec_cnt++; if (g !== {2'd1, 1'b1, 1'b1, 8'd1}) begin err_cnt++; $display("FAIL confirm_hit: got %h want 701", g); end
        step(2'b01, 1'b0);
        g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
        vec_cnt++; if (g !== {2'd1, 1'b1, 1'b0, 8'd1}) begin err_cnt++; $display("FAIL confirm_hold: got %h want 601", g); end
    endtask

    task automatic test_restart();
        logic [11:0] g;
        logic [1:0]  seq [5] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(seq[i], 1'b0);
            g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
            vec_cnt++; if (g !== 12'h000) begin err_cnt++; $display("FAIL restart_wait%0d: got %h want 000", i, g); end
        end
        step(2'b10, 1'b0);
        g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
        vec_cnt++; if (g !== {2'd2, 1'b1, 1'b1, 8'd1}) begin err_cnt++; $display("FAIL restart_hit: got %h want b01", g); end
    endtask

    task automatic test_escalate();
        logic [11:0] g;
        do_reset();
        repeat (3) step(2'b01, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(2'b11, 1'b0);
            g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
            vec_cnt++; if (g !== {2'd1, 1'b1, 1'b0, 8'd1}) begin err_cnt++; $display("FAIL esc_wait%0d: got %h want 601", i, g); end
        end
        step(2'b11, 1'b0);
        g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
        vec_cnt++; if (g !== {2'd3, 1'b1, 1'b1, 8'd2}) begin err_cnt++; $display("FAIL esc_hit: got %h want f02", g); end
        for (int i = 0; i < 5; i++) begin
            step(2'b01, 1'b0);
            g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
            vec_cnt++; if (g !== {2'd3, 1'b1, 1'b0, 8'd2}) begin err_cnt++; $display("FAIL esc_nolower%0d: got %h want e02", i, g); end
        end
    endtask

    task automatic test_clear();
        logic [11:0] g;
        logic [11:0] e;
        do_reset();
        repeat (3) step(2'b01, 1'b0);
        step(2'b10, 1'b1);
        g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
        vec_cnt++; if (g !== {2'd1, 1'b1, 1'b0, 8'd1}) begin err_cnt++; $display("FAIL clr_ack_ignored: got %h want 601", g); end
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 1'b0);
`ifdef NERVOUS_AUTO_CLEAR_EN
            e = (i == 3) ? {2'd0, 1'b0, 1'b0, 8'd1} : {2'd1, 1'b1, 1'b0, 8'd1};
`else
            e = {2'd1, 1'b1, 1'b0, 8'd1};
`endif
            g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
            vec_cnt++; if (g !== e) begin err_cnt++; $display("FAIL clr_noack%0d: got %h want %h", i, g, e); end
        end
        do_reset();
        repeat (3) step(2'b01, 1'b0);
        step(2'b00, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(2'b00, 1'b0);
            g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
            vec_cnt++; if (g !== {2'd1, 1'b1, 1'b0, 8'd1}) begin err_cnt++; $display("FAIL clr_pending%0d: got %h want 601", i, g); end
        end
        step(2'b00, 1'b0);
        g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
        vec_cnt++; if (g !== {2'd0, 1'b0, 1'b0, 8'd1}) begin err_cnt++; $display("FAIL clr_done: got %h want 001", g); end
        repeat (3) step(2'b01, 1'b0);
        step(2'b00, 1'b1);
        step(2'b00, 1'b0);
        step(2'b01, 1'b0);
        g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
        vec_cnt++; if (g !== {2'd1, 1'b1, 1'b0, 8'd2}) begin err_cnt++; $display("FAIL clr_abort: got %h want 602", g); end
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0);
            g = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
            vec_cnt++; if (g !== {2'd1, 1'b1, 1'b0, 8'd2}) begin err_cnt++; $display("FAIL clr_reack%0d: got %h want 602", i, g); end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] evs [5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        logic [2:0] g1;
        int want;
        do_reset();
        for (int e = 0; e < 5; e++) begin
            if (e == 3) begin
                step(2'b00, 1'b1);
                repeat (3) step(2'b00, 1'b0);
                vec_cnt++; if (if1.alarm_active !== 1'b0) begin err_cnt++; $display("FAIL sat_cleared: got %b want 0", if1.alarm_active); end
            end
            repeat (3) step(evs[e], 1'b0);
            want = (e + 1 > 3) ? 3 : e + 1;
            g1 = {if1.alarm_new, if1.event_count};
            vec_cnt++; if (g1 !== {1'b1, 2'(want)}) begin err_cnt++; $display("FAIL sat_u1_ev%0d: got %h want %h", e + 1, g1, {1'b1, 2'(want)}); end
            vec_cnt++; if (if0.event_count !== 8'(e + 1)) begin err_cnt++; $display("FAIL sat_u0_ev%0d: got %0d want %0d", e + 1, if0.event_count, e + 1); end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] g0;
        logic [5:0]  g1;
        logic [11:0] g2;
        do_reset();
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        g2 = {if2.alarm_level, if2.alarm_active, if2.alarm_new, if2.event_count};
        vec_cnt++; if (g2 !== {2'd1, 1'b1, 1'b0, 8'd1}) begin err_cnt++; $display("FAIL arst_pre_u2: got %h want 601", g2); end
        for (int r = 0; r < 2; r++) begin
            #2;
            reset_n = 1'b0;
            #1;
            g0 = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
            g1 = {if1.alarm_level, if1.alarm_active, if1.alarm_new, if1.event_count};
            g2 = {if2.alarm_level, if2.alarm_active, if2.alarm_new, if2.event_count};
            vec_cnt++; if (g0 !== 12'h000) begin err_cnt++; $display("FAIL arst%0d_u0: got %h want 000", r, g0); end
            vec_cnt++; if (g1 !== 6'h00)   begin err_cnt++; $display("FAIL arst%0d_u1: got %h want 00", r, g1); end
            vec_cnt++; if (g2 !== 12'h000) begin err_cnt++; $display("FAIL arst%0d_u2: got %h want 000", r, g2); end
            @(negedge clock);
            reset_n = 1'b1;
            if (r == 0) begin
                repeat (3) step(2'b01, 1'b0);
                vec_cnt++; if (if0.alarm_active !== 1'b1) begin err_cnt++; $display("FAIL arst_realarm: got %b want 1", if0.alarm_active); end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  cur;
        logic        a;
        logic [11:0] g0, e0, g2, e2;
        logic [5:0]  g1, e1;
        do_reset();
        model_reset();
        cur = 2'b00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 3) == 0) cur = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 2) == 0);
            step(cur, a);
            model_step(int'(cur), int'(a));
            g0 = {if0.alarm_level, if0.alarm_active, if0.alarm_new, if0.event_count};
            g1 = {if1.alarm_level, if1.alarm_active, if1.alarm_new, if1.event_count};
            g2 = {if2.alarm_level, if2.alarm_active, if2.alarm_new, if2.event_count};
            e0 = {2'(m_lvl[0]), 1'(m_ph[0] >= 2), 1'(m_new[0]), 8'(m_cnt[0])};
            e1 = {2'(m_lvl[1]), 1'(m_ph[1] >= 2), 1'(m_new[1]), 2'(m_cnt[1])};
            e2 = {2'(m_lvl[2]), 1'(m_ph[2] >= 2), 1'(m_new[2]), 8'(m_cnt[2])};
            vec_cnt++; if (g0 !== e0) begin err_cnt++; $display("FAIL rand_u0 cyc %0d: got %h want %h", cyc, g0, e0); end
            vec_cnt++; if (g1 !== e1) begin err_cnt++; $display("FAIL rand_u1 cyc %0d: got %h want %h", cyc, g1, e1); end
            vec_cnt++; if (g2 !== e2) begin err_cnt++; $display("FAIL rand_u2 cyc %0d: got %h want %h", cyc, g2, e2); end
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset_n = 1'b0;
                #1;
                reset_n = 1'b1;
                model_reset();
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        code_d  = 2'b00;
        ack_d   = 1'b0;
        test_reset();
        test_confirm();
        test_restart();
        test_escalate();
        test_clear();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
